fft_result_tx_packer: RTL and testbench

Output side of the FFT datapath: it accepts complex FFT results (`Re_i`/`Im_i`, `bit_width`-bit signed, 8 fractional bits) as one-cycle strobes at full FFT rate. It buffers one frame of `N` samples, converts each component back to a saturated 16-bit signed integer and streams the bytes to the UART byte transmitter through a start/busy handshake. It is the counterpart of the input byte-to-sample unpacker, which expands received bytes to `{sign, byte, 8'd0}`; this block performs the inverse scaling.

---
 rtl/fft_result_tx_packer_if.sv | 29 ++
 rtl/fft_result_tx_packer.sv | 253 +++++++++++++++++++++++++
 tb/tb_fft_result_tx_packer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_result_tx_packer_if.sv
// Sample-in / UART-byte-out bundle for the FFT result packer.
// Latency: none, this is wiring only.
// Backpressure: tx_busy from the UART side stalls the byte stream. Samples have no ready signal.
interface fft_result_tx_packer_if #(
  parameter int bit_width = 32
);
  logic signed [bit_width-1:0] Re_i;
  logic signed [bit_width-1:0] Im_i;
  logic                        en_i;
  logic                        tx_busy;
  logic [7:0]                  tx_data;
  logic                        tx_start;
  logic                        fifo_full;
  logic                        overflow;
  logic                        busy;
  logic                        frame_done;

  // Driving side: the FFT core and the UART transmitter.
  modport master (
    output Re_i, Im_i, en_i, tx_busy,
    input  tx_data, tx_start, fifo_full, overflow, busy, frame_done
  );

  // Packer side.
  modport slave (
    input  Re_i, Im_i, en_i, tx_busy,
    output tx_data, tx_start, fifo_full, overflow, busy, frame_done
  );
endinterface

// File: rtl/fft_result_tx_packer.sv
// Generic synchronous FIFO with a power-of-two depth and a combinational read port.
// Latency: a written entry can be popped on the following cycle.
// Backpressure: a write while full is accepted only if a pop happens in the same cycle; wr_acc reports acceptance.
module fft_result_tx_packer_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  output logic          wr_acc,
  input  logic          rd_pop,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   level,
  output logic [AW:0]   level_nxt
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_pop;

  assign full   = (level == FULL_LVL);
  assign do_pop = rd_pop && (level != '0);
  // The slot being freed this cycle can take the incoming entry.
  assign wr_acc = wr_vld && (!full || do_pop);
  assign rd_dat = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_nxt = level;
    case ({wr_acc, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Buffers one frame of complex FFT results, scales each component to saturated int16 and sends 4 bytes per sample to a UART.
// Latency: tx_start for the first byte comes 2 cycles after the strobe that lands in an empty, idle packer.
// Backpressure: tx_busy stalls SEND/WAIT. Samples arriving while the FIFO is full (and no pop is happening) are dropped and set sticky overflow.
module fft_result_tx_packer #(
  parameter int bit_width = 32,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input logic                   clk,
  input logic                   rst,
  fft_result_tx_packer_if.slave bus
);
  typedef struct packed {
    logic signed [bit_width-1:0] re;
    logic signed [bit_width-1:0] im;
  } sample_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_HOLD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic signed [bit_width-1:0] SAT_HI    = bit_width'(32767);
  localparam logic signed [bit_width-1:0] SAT_LO    = bit_width'(-32768);
  localparam logic [SIZE:0]               FRAME_LEN = (SIZE+1)'(N);

  // Drop the 8 fractional bits and clamp to int16. For narrow inputs the clamps are constant-false.
  function automatic logic [15:0] to_int16(input logic signed [bit_width-1:0] x);
    logic signed [bit_width-1:0] v;
    v = x >>> 8;
    if (v > SAT_HI)      to_int16 = 16'h7FFF;
    else if (v < SAT_LO) to_int16 = 16'h8000;
    else                 to_int16 = v[15:0];
  endfunction

  sample_t       wr_sample;
  sample_t       rd_sample;
  logic          wr_acc;
  logic [SIZE:0] level;
  logic [SIZE:0] level_nxt;

  state_t        state;
  state_t        state_nxt;
  logic          pop;
  logic          idx_inc;
  logic          cnt_inc;
  logic          cnt_clr;
  logic          tx_start_c;
  logic          frame_done_c;

  logic [15:0]   re_q;
  logic [15:0]   im_q;
  logic [1:0]    byte_idx;
  logic [SIZE:0] sample_cnt;
  logic [7:0]    tx_byte;

  logic          fifo_full_q;
  logic          busy_q;
  logic          overflow_q;

  assign wr_sample.re = bus.Re_i;
  assign wr_sample.im = bus.Im_i;

  fft_result_tx_packer_fifo #(
    .W     ($bits(sample_t)),
    .DEPTH (N),
    .AW    (SIZE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_vld    (bus.en_i),
    .wr_dat    (wr_sample),
    .wr_acc    (wr_acc),
    .rd_pop    (pop),
    .rd_dat    (rd_sample),
    .level     (level),
    .level_nxt (level_nxt)
  );

  // LOAD is the only state that consumes a FIFO entry.
  assign pop = (state == S_LOAD);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt    = state;
    idx_inc      = 1'b0;
    cnt_inc      = 1'b0;
    cnt_clr      = 1'b0;
    tx_start_c   = 1'b0;
    frame_done_c = 1'b0;
    unique case (state)
      // Also leave IDLE on the push happening now, so the first byte starts two cycles after the strobe.
      S_IDLE: begin
        if ((level != '0) || wr_acc) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          state_nxt  = S_HOLD;
        end
      end
      // The transmitter may need a cycle to raise busy, so it is not looked at here.
      S_HOLD: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.tx_busy) begin
          if (byte_idx != 2'd3) begin
            idx_inc   = 1'b1;
            state_nxt = S_SEND;
          end else begin
            cnt_inc = 1'b1;
            if ((sample_cnt + 1'b1) == FRAME_LEN) state_nxt = S_DONE;
            else if (level != '0)                 state_nxt = S_LOAD;
            else                                  state_nxt = S_IDLE;
          end
        end
      end
      S_DONE: begin
        frame_done_c = 1'b1;
        cnt_clr      = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scaled sample holding registers, byte index and frame sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_q       <= '0;
      im_q       <= '0;
      byte_idx   <= '0;
      sample_cnt <= '0;
    end else begin
      if (pop) begin
        re_q     <= to_int16(rd_sample.re);
        im_q     <= to_int16(rd_sample.im);
        byte_idx <= '0;
      end else if (idx_inc) begin
        byte_idx <= byte_idx + 1'b1;
      end
      if (cnt_clr)      sample_cnt <= '0;
      else if (cnt_inc) sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // Big-endian byte order: Re high, Re low, Im high, Im low. Stable until byte_idx or the sample changes.
  always_comb begin
    tx_byte = re_q[15:8];
    case (byte_idx)
      2'd0: tx_byte = re_q[15:8];
      2'd1: tx_byte = re_q[7:0];
      2'd2: tx_byte = im_q[15:8];
      2'd3: tx_byte = im_q[7:0];
      default: tx_byte = re_q[15:8];
    endcase
  end

  // Registered status flags showing the state after this cycle's push/pop. Overflow is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_full_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      fifo_full_q <= (level_nxt == FRAME_LEN);
      busy_q      <= (state_nxt != S_IDLE) || (level_nxt != '0);
      if (bus.en_i && !wr_acc) overflow_q <= 1'b1;
    end
  end

  assign bus.tx_data    = tx_byte;
  assign bus.tx_start   = tx_start_c;
  assign bus.frame_done = frame_done_c;
  assign bus.fifo_full  = fifo_full_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fft_result_tx_packer.sv
// Scoreboard bench for fft_result_tx_packer: stimulus queues expected bytes, a monitor checks every tx_start.
// A UART model raises tx_busy for busy_len cycles after each tx_start, or holds it high while hold_busy is set.
module tb_fft_result_tx_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_result_tx_packer_if #(.bit_width(32)) bus ();

  fft_result_tx_packer #(
    .bit_width (32),
    .N         (16),
    .SIZE      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         tests_run = 0;
  int         fails     = 0;
  int         cyc       = 0;
  logic [7:0] exp_q[$];
  int         start_log[$];
  int         byte_cnt    = 0;
  int         fd_cnt      = 0;
  int         fd_at_bytes = 0;
  int         fd_cyc      = 0;
  logic       prev_start  = 1'b0;
  int         busy_len    = 10;
  logic       hold_busy   = 1'b0;

  int base, base2, fdb, c0, target;

  // Saturation vectors: inputs and hand-computed int16 results.
  logic [31:0] sat_re  [4] = '{32'h0100_0000, 32'h007F_FF00, 32'h0080_0000, 32'hFFFF_FE80};
  logic [31:0] sat_im  [4] = '{32'hFF00_0000, 32'hFF80_0000, 32'hFF7F_FF00, 32'h0000_00FF};
  logic [15:0] sat_xre [4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFE};
  logic [15:0] sat_xim [4] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_sample(input logic [15:0] r, input logic [15:0] i);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(i[15:8]);
    exp_q.push_back(i[7:0]);
  endtask

  task automatic drive(input logic [31:0] re, input logic [31:0] im);
    bus.Re_i = re;
    bus.Im_i = im;
    bus.en_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (!bus.busy && !bus.tx_busy && exp_q.size() == 0) return;
    end
    tests_run++;
    fails++;
    $display("FAIL %s: timeout, %0d bytes still expected, busy=%0b", name, exp_q.size(), bus.busy);
  endtask

  task automatic wait_bytes(input string name, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (byte_cnt >= n) return;
    end
    tests_run++;
    fails++;
    $display("FAIL %s: timeout, got %0d bytes, required %0d", name, byte_cnt, n);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
  endtask

  // UART model: busy for busy_len cycles starting the cycle after tx_start.
  initial begin
    int rem;
    rem = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start && !rst) rem = busy_len;
      @(posedge clk);
      #1;
      if (rem > 0) begin
        bus.tx_busy = 1'b1;
        rem--;
      end else begin
        bus.tx_busy = hold_busy;
      end
    end
  end

  // Monitor: every tx_start pops one expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_start) begin
        check("tx_start_gap", prev_start, 1'b0);
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_byte: got %0h, no byte required", bus.tx_data);
        end else begin
          check($sformatf("tx_byte_%0d", byte_cnt), bus.tx_data, exp_q.pop_front());
        end
        byte_cnt++;
        start_log.push_back(cyc);
      end
      if (bus.frame_done) begin
        fd_cnt++;
        fd_at_bytes = byte_cnt;
        fd_cyc      = cyc;
      end
    end
    prev_start = bus.tx_start;
  end

  // Watchdog against a hung run.
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    bus.Re_i = '0;
    bus.Im_i = '0;
    bus.en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_data",    bus.tx_data,    8'h00);
    check("rst_tx_start",   bus.tx_start,   1'b0);
    check("rst_fifo_full",  bus.fifo_full,  1'b0);
    check("rst_overflow",   bus.overflow,   1'b0);
    check("rst_busy",       bus.busy,       1'b0);
    check("rst_frame_done", bus.frame_done, 1'b0);
    rst = 1'b0;
    step();

    // Basic bytes and first-byte latency.
    busy_len = 10;
    base = byte_cnt;
    c0 = cyc;
    drive(32'h0000_1234, 32'hFFFF_FF00);
    expect_sample(16'h0012, 16'hFFFF);
    step();
    bus.en_i = 1'b0;
    wait_drain("basic_drain", 500);
    check("basic_bytes", byte_cnt - base, 4);
    check("basic_first_start", (start_log.size() > base) ? start_log[base] - c0 : -1, 2);
    apply_reset();

    // Saturation and rounding boundaries.
    busy_len = 3;
    base = byte_cnt;
    for (int k = 0; k < 4; k++) begin
      drive(sat_re[k], sat_im[k]);
      expect_sample(sat_xre[k], sat_xim[k]);
      step();
    end
    bus.en_i = 1'b0;
    wait_drain("sat_drain", 1000);
    check("sat_bytes", byte_cnt - base, 16);
    apply_reset();

    // Full frame of 16 back-to-back samples.
    busy_len = 2;
    base = byte_cnt;
    fdb = fd_cnt;
    for (int k = 0; k < 16; k++) begin
      drive(32'(k) << 8, -(32'(k) << 8));
      expect_sample(16'(k), 16'(-k));
      step();
    end
    bus.en_i = 1'b0;
    check("frame_burst_overflow", bus.overflow, 1'b0);
    wait_drain("frame_drain", 2000);
    check("frame_bytes", byte_cnt - base, 64);
    check("frame_done_count", fd_cnt - fdb, 1);
    check("frame_done_after_byte", fd_at_bytes - base, 64);
    check("frame_done_timing", fd_cyc - start_log[start_log.size() - 1], busy_len + 2);
    check("frame_overflow", bus.overflow, 1'b0);
    apply_reset();

    // Overflow: the first sample leaves the FIFO in LOAD and waits in SEND, 16 more fill it, the 18th is dropped.
    hold_busy = 1'b1;
    busy_len = 1;
    repeat (2) step();
    base = byte_cnt;
    fdb = fd_cnt;
    for (int i = 0; i < 18; i++) begin
      drive(32'(i) << 8, 32'(i + 1) << 8);
      if (i < 17) expect_sample(16'(i), 16'(i + 1));
      step();
      if (i == 15) check("ovf_not_full_16", bus.fifo_full, 1'b0);
      if (i == 16) begin
        check("ovf_full_17", bus.fifo_full, 1'b1);
        check("ovf_clear_17", bus.overflow, 1'b0);
      end
    end
    bus.en_i = 1'b0;
    check("ovf_set", bus.overflow, 1'b1);
    check("ovf_busy", bus.busy, 1'b1);
    check("ovf_no_bytes_while_busy", byte_cnt - base, 0);
    hold_busy = 1'b0;
    wait_drain("ovf_drain", 3000);
    check("ovf_bytes", byte_cnt - base, 68);
    check("ovf_sticky", bus.overflow, 1'b1);
    check("ovf_frame_done", fd_cnt - fdb, 1);
    check("ovf_frame_done_pos", fd_at_bytes - base, 64);
    apply_reset();
    check("ovf_rst_clear", bus.overflow, 1'b0);

    // Push while full, coinciding with the LOAD pop.
    hold_busy = 1'b1;
    busy_len = 2;
    repeat (2) step();
    base = byte_cnt;
    fdb = fd_cnt;
    for (int i = 0; i < 17; i++) begin
      drive(32'(i + 32) << 8, 32'(i) << 8);
      expect_sample(16'(i + 32), 16'(i));
      step();
    end
    bus.en_i = 1'b0;
    check("pwf_full_before", bus.fifo_full, 1'b1);
    check("pwf_ovf_before", bus.overflow, 1'b0);
    hold_busy = 1'b0;
    wait_bytes("pwf_first_sample", base + 4, 500);
    // Fourth byte at t: busy t+1..t+busy_len, WAIT exits at t+busy_len+1, LOAD at t+busy_len+2.
    target = start_log[start_log.size() - 1] + busy_len + 2;
    for (int i = 0; i < 50 && cyc < target; i++) step();
    drive(32'h0000_5500, 32'hFFFF_AB00);
    expect_sample(16'h0055, 16'hFFAB);
    step();
    bus.en_i = 1'b0;
    check("pwf_overflow", bus.overflow, 1'b0);
    check("pwf_full_after", bus.fifo_full, 1'b1);
    wait_drain("pwf_drain", 3000);
    check("pwf_bytes", byte_cnt - base, 72);
    check("pwf_frame_done", fd_cnt - fdb, 1);
    apply_reset();

    // Reset in the middle of byte 2 of sample 5.
    busy_len = 2;
    base = byte_cnt;
    for (int k = 0; k < 16; k++) begin
      drive(32'(k) << 8, -(32'(k) << 8));
      expect_sample(16'(k), 16'(-k));
      step();
    end
    bus.en_i = 1'b0;
    wait_bytes("mid_reach_byte", base + 23, 2000);
    check("mid_tx_data", bus.tx_data, 8'hFF);
    check("mid_busy", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tx_data",    bus.tx_data,    8'h00);
    check("mid_rst_tx_start",   bus.tx_start,   1'b0);
    check("mid_rst_fifo_full",  bus.fifo_full,  1'b0);
    check("mid_rst_overflow",   bus.overflow,   1'b0);
    check("mid_rst_busy",       bus.busy,       1'b0);
    check("mid_rst_frame_done", bus.frame_done, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base2 = byte_cnt;
    fdb = fd_cnt;
    repeat (20) step();
    check("rst_no_start", byte_cnt - base2, 0);
    check("rst_idle", bus.busy, 1'b0);
    for (int k = 0; k < 16; k++) begin
      drive(32'(k + 64) << 8, -(32'(k + 1) << 8));
      expect_sample(16'(k + 64), 16'(-(k + 1)));
      step();
    end
    bus.en_i = 1'b0;
    wait_drain("rst_new_frame_drain", 2000);
    check("rst_new_frame_bytes", byte_cnt - base2, 64);
    check("rst_new_frame_done", fd_cnt - fdb, 1);
    check("rst_new_frame_done_pos", fd_at_bytes - base2, 64);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
